mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 80, maximum cycles to wait for mul_done.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
REQ-008 req_a, req_b  input  NUM_REQ x WIDTH  per-requester operands.
REQ-009 req_signed  input  NUM_REQ  per-requester signed-operation select.
REQ-010 mul_load  output  1  one-cycle start pulse to the shared multiplier.
REQ-011 mul_a, mul_b  output  WIDTH  registered operands to the multiplier.
REQ-012 mul_signed  output  1  registered sign select to the multiplier.
REQ-013 mul_done  input  1  one-cycle completion pulse from the multiplier.
REQ-014 mul_result  input  2*WIDTH  product, valid when mul_done=1.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  response consumer ready.
REQ-017 rsp_id  output  clog2(NUM_REQ)  index of the requester owning the response.
REQ-018 rsp_result  output  2*WIDTH  product, or zero on timeout.
REQ-019 rsp_error  output  1  response produced by timeout, not by mul_done.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: if any req_valid bit is set, SHALL grant exactly one requester via round-robin, starting at the index after the last granted one; the pointer resets to 0.
REQ-022 Grant cycle: SHALL assert req_ready[g] for one cycle; SHALL latch req_a[g], req_b[g], req_signed[g] and g; next state ISSUE.
REQ-023 A request SHALL transfer only when req_valid[g] and req_ready[g] are both 1 in the same cycle.
REQ-024 ISSUE: SHALL assert mul_load for exactly one cycle, with mul_a, mul_b and mul_signed stable; SHALL clear the timeout counter; next state WAIT.
REQ-025 WAIT: SHALL increment the timeout counter each cycle.
REQ-026 WAIT, mul_done=1: SHALL capture mul_result into rsp_result and set rsp_error=0; next state RESP.
REQ-027 WAIT, counter reaches TIMEOUT with no mul_done: SHALL set rsp_result=0 and rsp_error=1; next state RESP.
REQ-028 mul_done arriving in the same cycle the counter reaches TIMEOUT SHALL take priority (no error).
REQ-029 mul_done seen outside WAIT SHALL be ignored.
REQ-030 RESP: SHALL hold rsp_valid=1 with rsp_id, rsp_result and rsp_error stable until rsp_ready=1; on that cycle SHALL advance the round-robin pointer to rsp_id+1 (mod NUM_REQ) and go to IDLE.
REQ-031 SHALL allow at most one multiplication outstanding; req_ready SHALL be all-zero outside the IDLE grant cycle.
REQ-032 Minimum request-to-response latency SHALL be 3 cycles plus multiplier latency; IDLE SHALL re-arbitrate on the cycle after a RESP handshake.
REQ-033 Requester deasserting req_valid before grant SHALL lose no state and SHALL not be granted.

Reset
REQ-034 On rst=1, asynchronously: state=IDLE, pointer=0, counter=0; req_ready, mul_load, rsp_valid and rsp_error=0; mul_a, mul_b, mul_signed, rsp_id and rsp_result=0.
REQ-035 rst asserted during WAIT or RESP SHALL abort the operation, and no response SHALL be emitted; a late mul_done after reset SHALL be ignored.

Verification
REQ-036 Single request: req_valid[2]=1, a=7, b=6, unsigned; model returns 42 after 34 cycles -> one mul_load pulse, rsp_id=2, rsp_result=42, rsp_error=0.
REQ-037 Contention: all four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0; never two req_ready bits high at once.
REQ-038 Signed: a=-3, b=5, req_signed=1 -> mul_signed=1 during mul_load; rsp_result=-15 sign-extended to 2*WIDTH.
REQ-039 Timeout: model never pulses mul_done, TIMEOUT=80 -> RESP entered 80 cycles after ISSUE, rsp_error=1, rsp_result=0; mul_done coinciding with cycle 80 -> rsp_error=0.
REQ-040 Backpressure: rsp_ready=0 for 10 cycles in RESP -> outputs stable, no new grant; grant occurs one cycle after rsp_ready=1.
REQ-041 Reset mid-WAIT: assert rst, then a stale mul_done -> all outputs zero, no rsp_valid, next grant starts at requester 0.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among NUM_REQ
// requesters. One multiplication is in flight at a time; a missing
// completion is turned into an error response after TIMEOUT cycles.
module mult_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 80
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_b,
    input  logic [NUM_REQ-1:0]                req_signed,
    output logic                              mul_load,
    output logic [WIDTH-1:0]                  mul_a,
    output logic [WIDTH-1:0]                  mul_b,
    output logic                              mul_signed,
    input  logic                              mul_done,
    input  logic [2*WIDTH-1:0]                mul_result,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]                rsp_result,
    output logic                              rsp_error
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned IW1 = IDW + 1;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_owner;
    logic [CW-1:0]      r_cnt;
    logic               r_mul_load;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic               r_mul_signed;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [2*WIDTH-1:0] r_rsp_result;
    logic               r_rsp_error;

    logic               w_any;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IW1-1:0]     w_idx;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IW1'(r_ptr) + IW1'(k);
            if (w_idx >= IW1'(NUM_REQ)) begin
                w_idx = w_idx - IW1'(NUM_REQ);
            end
            if (!w_any && req_valid[w_idx[IDW-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_idx[IDW-1:0];
            end
        end
    end

    // Grant is offered only while idle so the handshake sees the live req_valid.
    always_comb begin
        req_ready = '0;
        if (!rst && r_state == S_IDLE && w_any) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Main controller: grant, issue, wait for completion or timeout, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_mul_load   <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_signed <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            r_mul_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_gnt_idx;
                        r_mul_a      <= req_a[w_gnt_idx];
                        r_mul_b      <= req_b[w_gnt_idx];
                        r_mul_signed <= req_signed[w_gnt_idx];
                        r_mul_load   <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Completion wins over a timeout landing on the same cycle.
                    if (mul_done) begin
                        r_rsp_result <= mul_result;
                        r_rsp_error  <= 1'b0;
                        r_rsp_id     <= r_owner;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rsp_result <= '0;
                        r_rsp_error  <= 1'b1;
                        r_rsp_id     <= r_owner;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= (r_owner == IDW'(NUM_REQ - 1)) ? '0 : r_owner + IDW'(1);
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_load   = r_mul_load;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_signed = r_mul_signed;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter with a transaction-level reference
// model and a behavioural multiplier driven from the stimulus thread.
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 80;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N-1:0][W-1:0]     req_a;
    logic [N-1:0][W-1:0]     req_b;
    logic [N-1:0]            req_signed;
    logic                    mul_load;
    logic [W-1:0]            mul_a;
    logic [W-1:0]            mul_b;
    logic                    mul_signed;
    logic                    mul_done;
    logic [2*W-1:0]          mul_result;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [$clog2(N)-1:0]    rsp_id;
    logic [2*W-1:0]          rsp_result;
    logic                    rsp_error;

    mult_share_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .mul_load   (mul_load),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: round-robin start index and the expected transaction.
    int             ptr_m = 0;
    int             exp_g;
    logic [W-1:0]   exp_a;
    logic [W-1:0]   exp_b;
    logic           exp_s;
    logic [2*W-1:0] exp_res;
    logic           exp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [2*W-1:0] x;
        logic signed [2*W-1:0] y;
        if (s) begin
            x = {{W{a[W-1]}}, a};
            y = {{W{b[W-1]}}, b};
        end else begin
            x = {{W{1'b0}}, a};
            y = {{W{1'b0}}, b};
        end
        return x * y;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle: present requests and check the grant chosen.
    task automatic do_grant(input logic [N-1:0] mask, input bit force_op,
                            input logic [W-1:0] fa, input logic [W-1:0] fb, input logic fs,
                            output int g);
        logic [N-1:0] oh;
        tick();
        rsp_ready = 1'b0;
        mul_done  = 1'b0;
        req_valid = mask;
        for (int i = 0; i < N; i++) begin
            req_a[i]      = force_op ? fa : W'($urandom());
            req_b[i]      = force_op ? fb : W'($urandom());
            req_signed[i] = force_op ? fs : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        exp_g = model_pick(mask, ptr_m);
        oh = '0;
        oh[exp_g] = 1'b1;
        check_eq("grant", 64'(req_ready), 64'(oh));
        check_eq("no_rsp_idle", 64'(rsp_valid), 64'd0);
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        exp_a = req_a[exp_g];
        exp_b = req_b[exp_g];
        exp_s = req_signed[exp_g];
    endtask

    task automatic check_issue();
        tick();
        req_valid = '0;
        @(negedge clk);
        check_eq("mul_load", 64'(mul_load), 64'd1);
        check_eq("mul_a", 64'(mul_a), 64'(exp_a));
        check_eq("mul_b", 64'(mul_b), 64'(exp_b));
        check_eq("mul_signed", 64'(mul_signed), 64'(exp_s));
        check_eq("ready_issue", 64'(req_ready), 64'd0);
    endtask

    // Behavioural multiplier: completes after lat WAIT cycles, or never.
    task automatic wait_phase(input int lat, input bit done_en);
        int             k_end;
        logic [2*W-1:0] prod;
        k_end = done_en ? lat : TO;
        prod  = ref_mul(exp_a, exp_b, exp_s);
        for (int k = 1; k <= k_end; k++) begin
            tick();
            mul_done   = done_en && (k == lat);
            mul_result = mul_done ? prod : {$urandom(), $urandom()};
            req_valid  = N'($urandom());
            @(negedge clk);
            check_eq("load_once", 64'(mul_load), 64'd0);
            check_eq("no_rsp_wait", 64'(rsp_valid), 64'd0);
            check_eq("ready_wait", 64'(req_ready), 64'd0);
        end
        tick();
        mul_done   = 1'b0;
        mul_result = {$urandom(), $urandom()};
        req_valid  = '0;
        exp_res = done_en ? prod : '0;
        exp_err = !done_en;
        @(negedge clk);
        check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("rsp_id", 64'(rsp_id), 64'(exp_g));
        check_eq("rsp_result", rsp_result, exp_res);
        check_eq("rsp_error", 64'(rsp_error), 64'(exp_err));
    endtask

    // Hold off the response for bp cycles with stray completions and requests.
    task automatic resp_phase(input int bp);
        for (int i = 0; i < bp; i++) begin
            tick();
            rsp_ready  = 1'b0;
            req_valid  = N'($urandom_range(1, (1 << N) - 1));
            mul_done   = 1'($urandom_range(0, 1));
            mul_result = {$urandom(), $urandom()};
            @(negedge clk);
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_id", 64'(rsp_id), 64'(exp_g));
            check_eq("hold_result", rsp_result, exp_res);
            check_eq("hold_error", 64'(rsp_error), 64'(exp_err));
            check_eq("ready_resp", 64'(req_ready), 64'd0);
            check_eq("load_resp", 64'(mul_load), 64'd0);
        end
        tick();
        rsp_ready = 1'b1;
        req_valid = '0;
        mul_done  = 1'b0;
        @(negedge clk);
        check_eq("hs_valid", 64'(rsp_valid), 64'd1);
        check_eq("hs_result", rsp_result, exp_res);
        ptr_m = (exp_g + 1) % N;
    endtask

    task automatic run_txn(input logic [N-1:0] mask, input bit force_op,
                           input logic [W-1:0] fa, input logic [W-1:0] fb, input logic fs,
                           input int lat, input bit done_en, input int bp, output int g);
        do_grant(mask, force_op, fa, fb, fs, g);
        check_issue();
        wait_phase(lat, done_en);
        resp_phase(bp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  g;
        bit  den;
        int  lat;
        rst        = 1'b1;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;
        mul_done   = 1'b0;
        mul_result = '0;
        rsp_ready  = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_eq("rst_load", 64'(mul_load), 64'd0);
        check_eq("rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_error", 64'(rsp_error), 64'd0);
        check_eq("rst_a", 64'(mul_a), 64'd0);
        check_eq("rst_id", 64'(rsp_id), 64'd0);
        check_eq("rst_result", rsp_result, 64'd0);
        tick();
        rst       = 1'b0;
        req_valid = '0;

        // Full contention: expect strict rotation 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            run_txn('1, 1'b0, '0, '0, 1'b0, $urandom_range(1, 4), 1'b1, 0, g);
            check_eq("rr_seq", 64'(g), 64'(i % N));
        end

        // Single request: 7*6 from requester 2, 34-cycle multiplier.
        run_txn(4'b0100, 1'b1, 32'd7, 32'd6, 1'b0, 34, 1'b1, 0, g);
        check_eq("single_res", rsp_result, 64'd42);

        // Signed: -3 * 5.
        run_txn(4'b0001, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, 3, 1'b1, 1, g);
        check_eq("signed_res", rsp_result, 64'hFFFF_FFFF_FFFF_FFF1);

        // Timeout without completion, then completion exactly on the last cycle.
        run_txn(4'b1000, 1'b0, '0, '0, 1'b0, 0, 1'b0, 0, g);
        run_txn(4'b0010, 1'b0, '0, '0, 1'b0, TO, 1'b1, 0, g);

        // Backpressure for 10 cycles, then immediate re-arbitration.
        run_txn(4'b0110, 1'b0, '0, '0, 1'b0, 5, 1'b1, 10, g);
        run_txn(4'b1111, 1'b0, '0, '0, 1'b0, 2, 1'b1, 0, g);

        // Reset mid-WAIT followed by a stale completion.
        do_grant(4'b1100, 1'b0, '0, '0, 1'b0, g);
        check_issue();
        for (int i = 0; i < 5; i++) begin
            tick();
            req_valid = '0;
        end
        tick();
        rst       = 1'b1;
        req_valid = '1;
        @(negedge clk);
        check_eq("mid_rst_ready", 64'(req_ready), 64'd0);
        check_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_a", 64'(mul_a), 64'd0);
        check_eq("mid_rst_b", 64'(mul_b), 64'd0);
        check_eq("mid_rst_sgn", 64'(mul_signed), 64'd0);
        check_eq("mid_rst_id", 64'(rsp_id), 64'd0);
        check_eq("mid_rst_res", rsp_result, 64'd0);
        tick();
        rst        = 1'b0;
        req_valid  = '0;
        mul_done   = 1'b1;
        mul_result = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check_eq("stale_valid", 64'(rsp_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            mul_done = 1'b0;
            @(negedge clk);
            check_eq("post_rst_valid", 64'(rsp_valid), 64'd0);
            check_eq("post_rst_load", 64'(mul_load), 64'd0);
            check_eq("post_rst_res", rsp_result, 64'd0);
        end
        ptr_m = 0;
        run_txn('1, 1'b0, '0, '0, 1'b0, 2, 1'b1, 0, g);
        check_eq("rr_after_rst", 64'(g), 64'd0);

        // Randomized traffic.
        for (int r = 0; r < 40; r++) begin
            den = ($urandom_range(0, 7) != 0);
            lat = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(1, 12);
            run_txn(N'($urandom_range(1, (1 << N) - 1)), 1'b0, '0, '0, 1'b0,
                    lat, den, $urandom_range(0, 3), g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
